// File: rtl/multi_roc_pattern_gen.sv
// Simulated ROC event generator: header + payload per event into NCHAN SIM_ROC_FIFOs.
// Define PATTERN_PRBS_EN to make pattern_mode 11 emit PRBS-31; otherwise mode 11 acts as the counter.
module multi_roc_pattern_gen #(
    parameter int NCHAN      = 4,
    parameter int DATA_W     = 32,
    parameter int HIT_W      = 10,
    parameter int TAG_W      = 20,
    parameter int ADDR_W     = 6,
    parameter int WPH        = 8,
    parameter int SHARE_HITS = 512,
    parameter int MAX_PEND   = 2
) (
    input  logic                      serdesclk,
    input  logic                      serdesclk_resetn,
    input  logic                      newspill_reset,
    input  logic                      haltrun_en,
    input  logic                      pattern_init,
    input  logic                      ddr_done,
    input  logic [HIT_W-1:0]          hit_in,
    input  logic [TAG_W-1:0]          ewtag_in,
    input  logic [1:0]                pattern_mode,
    input  logic [NCHAN-1:0]          fifo_full,
    output logic [NCHAN-1:0]          pattern_we,
    output logic [NCHAN*DATA_W-1:0]   pattern_data,
    output logic                      hit_re,
    output logic [ADDR_W-1:0]         hit_rdaddr,
    output logic [2:0]                pend_cnt,
    output logic                      hit_over,
    output logic                      hit_under,
    output logic                      size_ovf
);

    localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int SZ_W  = HIT_W + $clog2(WPH) + 1;
    localparam int SHIFT = $clog2(NCHAN);
    localparam logic [HIT_W-1:0] SHARE_V   = HIT_W'(SHARE_HITS);
    localparam logic [2:0]       MAXP_V    = 3'(MAX_PEND);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NCHAN - 1);
    localparam logic [SZ_W-1:0]  FIELD_MAX = SZ_W'(4095);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_WAIT1, S_HEADER, S_PAYLOAD, S_NEXTCH, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [CH_W-1:0]     cur_ch_reg, event_idx_reg;
    logic [HIT_W-1:0]    hits_reg;
    logic [SZ_W-1:0]     word_cnt_reg;
    logic [DATA_W-1:0]   counter_reg, walk_reg;
    logic                alt_reg;
    logic [NCHAN-1:0]    we_reg;
    logic                hit_re_reg;
    logic [ADDR_W-1:0]   rdaddr_reg;
    logic [2:0]          pend_reg;
    logic                over_reg, under_reg, ovf_reg;

    logic                hdr_wr, pl_wr, req_go, sample_hits, hit_filled;
    logic                ch_full;
    logic [NCHAN-1:0]    full_sh;
    logic [SZ_W-1:0]     size_full, ch_size;
    logic [DATA_W-1:0]   hdr_word, pl_word, wr_word, cnt_inc;
    logic                adv_cnt, adv_alt, adv_walk;
`ifdef PATTERN_PRBS_EN
    logic [30:0]         prbs_reg;
    logic                adv_prbs;
`endif

    assign full_sh   = fifo_full >> cur_ch_reg;
    assign ch_full   = full_sh[0];
    assign size_full = SZ_W'(hits_reg) * SZ_W'(WPH);
    assign cnt_inc   = counter_reg + DATA_W'(1);
    assign wr_word   = hdr_wr ? hdr_word : pl_word;

    // Shared events split evenly; otherwise only the owner carries payload.
    always_comb begin
        ch_size = '0;
        if (hits_reg == SHARE_V)
            ch_size = size_full >> SHIFT;
        else if (cur_ch_reg == event_idx_reg)
            ch_size = size_full;
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[DATA_W-1 -: 12] = (ch_size > FIELD_MAX) ? 12'hFFF : ch_size[11:0];
        hdr_word[TAG_W-1:0] = ewtag_in;
    end

    always_comb begin
        pl_word  = cnt_inc;
        adv_cnt  = 1'b0;
        adv_alt  = 1'b0;
        adv_walk = 1'b0;
`ifdef PATTERN_PRBS_EN
        adv_prbs = 1'b0;
`endif
        case (pattern_mode)
            2'b01: begin
                pl_word = alt_reg ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
                adv_alt = 1'b1;
            end
            2'b10: begin
                pl_word  = walk_reg;
                adv_walk = 1'b1;
            end
`ifdef PATTERN_PRBS_EN
            2'b11: begin
                pl_word  = DATA_W'(prbs_reg);
                adv_prbs = 1'b1;
            end
`endif
            default: adv_cnt = 1'b1;
        endcase
    end

    always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
        if (!serdesclk_resetn)
            state_reg <= S_IDLE;
        else if (newspill_reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        hdr_wr      = 1'b0;
        pl_wr       = 1'b0;
        req_go      = 1'b0;
        sample_hits = 1'b0;
        hit_filled  = 1'b0;
        case (state_reg)
            S_IDLE:   if (pattern_init) state_next = S_REQ;
            S_REQ: begin
                if (pend_reg < MAXP_V) begin
                    req_go     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT:   state_next = S_WAIT1;
            S_WAIT1: begin
                sample_hits = 1'b1;
                state_next  = S_HEADER;
            end
            S_HEADER: begin
                if (!ch_full) begin
                    hdr_wr     = 1'b1;
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (word_cnt_reg == ch_size)
                    state_next = S_NEXTCH;
                else if (!ch_full)
                    pl_wr = 1'b1;
            end
            S_NEXTCH: state_next = (cur_ch_reg == LAST_CH) ? S_DONE : S_HEADER;
            S_DONE: begin
                hit_filled = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
        if (!serdesclk_resetn) begin
            cur_ch_reg    <= '0;
            event_idx_reg <= '0;
            hits_reg      <= '0;
            word_cnt_reg  <= '0;
            counter_reg   <= '1;
            walk_reg      <= DATA_W'(1);
            alt_reg       <= 1'b0;
            we_reg        <= '0;
            hit_re_reg    <= 1'b0;
            rdaddr_reg    <= '0;
            pend_reg      <= '0;
            over_reg      <= 1'b0;
            under_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (newspill_reset) begin
            cur_ch_reg    <= '0;
            event_idx_reg <= '0;
            hits_reg      <= '0;
            word_cnt_reg  <= '0;
            alt_reg       <= 1'b0;
            we_reg        <= '0;
            hit_re_reg    <= 1'b0;
            pend_reg      <= '0;
            over_reg      <= 1'b0;
            under_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            if (!haltrun_en) begin
                counter_reg <= '1;
                walk_reg    <= DATA_W'(1);
                rdaddr_reg  <= '0;
            end
        end else begin
            we_reg     <= (hdr_wr || pl_wr) ? (NCHAN'(1) << cur_ch_reg) : '0;
            hit_re_reg <= req_go;
            if (sample_hits) begin
                hits_reg   <= hit_in;
                cur_ch_reg <= '0;
            end
            if (state_reg == S_NEXTCH && cur_ch_reg != LAST_CH)
                cur_ch_reg <= cur_ch_reg + CH_W'(1);
            if (hdr_wr) begin
                word_cnt_reg <= '0;
                if (ch_size > FIELD_MAX)
                    ovf_reg <= 1'b1;
            end
            if (pl_wr) begin
                word_cnt_reg <= word_cnt_reg + SZ_W'(1);
                if (adv_cnt)  counter_reg <= cnt_inc;
                if (adv_alt)  alt_reg     <= ~alt_reg;
                if (adv_walk) walk_reg    <= {walk_reg[DATA_W-2:0], walk_reg[DATA_W-1]};
            end
            if (hit_filled) begin
                rdaddr_reg    <= rdaddr_reg + ADDR_W'(1);
                event_idx_reg <= (event_idx_reg == LAST_CH) ? '0 : event_idx_reg + CH_W'(1);
            end
            // A fill and a drain in the same cycle cancel out.
            if (hit_filled && !ddr_done) begin
                if (pend_reg == MAXP_V) over_reg <= 1'b1;
                if (pend_reg != 3'd7)   pend_reg <= pend_reg + 3'd1;
            end else if (ddr_done && !hit_filled) begin
                if (pend_reg == 3'd0) under_reg <= 1'b1;
                else                  pend_reg  <= pend_reg - 3'd1;
            end
        end
    end

`ifdef PATTERN_PRBS_EN
    always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
        if (!serdesclk_resetn)
            prbs_reg <= 31'd1;
        else if (newspill_reset) begin
            if (!haltrun_en) prbs_reg <= 31'd1;
        end else if (pl_wr && adv_prbs)
            prbs_reg <= {prbs_reg[29:0], prbs_reg[30] ^ prbs_reg[27]};
    end
`endif

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_ch
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
                if (!serdesclk_resetn)
                    data_reg <= '0;
                else if (newspill_reset)
                    data_reg <= '0;
                else if ((hdr_wr || pl_wr) && cur_ch_reg == CH_W'(gi))
                    data_reg <= wr_word;
            end
            assign pattern_data[gi*DATA_W +: DATA_W] = data_reg;
        end
    endgenerate

    assign pattern_we = we_reg;
    assign hit_re     = hit_re_reg;
    assign hit_rdaddr = rdaddr_reg;
    assign pend_cnt   = pend_reg;
    assign hit_over   = over_reg;
    assign hit_under  = under_reg;
    assign size_ovf   = ovf_reg;

endmodule

// File: tb/tb_multi_roc_pattern_gen.sv
// Randomized bench for multi_roc_pattern_gen: an event-level model queues every expected FIFO word.
module tb_multi_roc_pattern_gen;

    localparam int NCHAN = 4, DATA_W = 32, HIT_W = 10, TAG_W = 20, ADDR_W = 6;
    localparam int WPH = 8, SHARE_HITS = 512, MAX_PEND = 2;
    localparam int TIMEOUT = 15000;

    logic                     serdesclk = 1'b0;
    logic                     serdesclk_resetn = 1'b0;
    logic                     newspill_reset = 1'b0;
    logic                     haltrun_en = 1'b0;
    logic                     pattern_init = 1'b0;
    logic                     ddr_done = 1'b0;
    logic [HIT_W-1:0]         hit_in = '0;
    logic [TAG_W-1:0]         ewtag_in = '0;
    logic [1:0]               pattern_mode = '0;
    logic [NCHAN-1:0]         fifo_full = '0;
    logic [NCHAN-1:0]         pattern_we;
    logic [NCHAN*DATA_W-1:0]  pattern_data;
    logic                     hit_re;
    logic [ADDR_W-1:0]        hit_rdaddr;
    logic [2:0]               pend_cnt;
    logic                     hit_over, hit_under, size_ovf;

    multi_roc_pattern_gen #(
        .NCHAN(NCHAN), .DATA_W(DATA_W), .HIT_W(HIT_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W),
        .WPH(WPH), .SHARE_HITS(SHARE_HITS), .MAX_PEND(MAX_PEND)
    ) dut (
        .serdesclk(serdesclk), .serdesclk_resetn(serdesclk_resetn),
        .newspill_reset(newspill_reset), .haltrun_en(haltrun_en),
        .pattern_init(pattern_init), .ddr_done(ddr_done),
        .hit_in(hit_in), .ewtag_in(ewtag_in), .pattern_mode(pattern_mode),
        .fifo_full(fifo_full), .pattern_we(pattern_we), .pattern_data(pattern_data),
        .hit_re(hit_re), .hit_rdaddr(hit_rdaddr), .pend_cnt(pend_cnt),
        .hit_over(hit_over), .hit_under(hit_under), .size_ovf(size_ovf)
    );

    always #5 serdesclk = ~serdesclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state (event level)
    logic [39:0]        exp_q[$];
    logic [31:0]        m_cnt = '1;
    logic [31:0]        m_walk = 32'd1;
    logic               m_alt = 1'b0;
    logic [30:0]        m_prbs = 31'd1;
    int                 m_evidx = 0, m_pend = 0, m_events = 0;
    logic [ADDR_W-1:0]  m_addr = '0;
    logic               m_ovf = 1'b0, m_under = 1'b0;
    int                 re_cnt = 0;

    logic               rand_full = 1'b0;
    logic [NCHAN-1:0]   forced_full = '0;
    logic [NCHAN-1:0]   full_at_edge = '0;

    task automatic tick();
        @(posedge serdesclk);
        #1;
    endtask

    task automatic gen_word(input logic [1:0] mode, output logic [31:0] w);
        case (mode)
            2'b01: begin w = m_alt ? 32'hAAAA_AAAA : 32'h5555_5555; m_alt = ~m_alt; end
            2'b10: begin w = m_walk; m_walk = {m_walk[30:0], m_walk[31]}; end
`ifdef PATTERN_PRBS_EN
            2'b11: begin w = {1'b0, m_prbs}; m_prbs = {m_prbs[29:0], m_prbs[30] ^ m_prbs[27]}; end
`endif
            default: begin m_cnt = m_cnt + 32'd1; w = m_cnt; end
        endcase
    endtask

    task automatic start_event(input int hits, input logic [TAG_W-1:0] tag, input logic [1:0] mode);
        int total, size;
        logic [31:0] hdr, w;
        hit_in = HIT_W'(hits);
        ewtag_in = tag;
        pattern_mode = mode;
        total = hits * WPH;
        for (int c = 0; c < NCHAN; c++) begin
            if (hits == SHARE_HITS) size = total / NCHAN;
            else size = (c == m_evidx) ? total : 0;
            hdr = '0;
            hdr[31:20] = (size > 4095) ? 12'hFFF : 12'(size);
            hdr[TAG_W-1:0] = tag;
            if (size > 4095) m_ovf = 1'b1;
            exp_q.push_back({8'(c), hdr});
            for (int k = 0; k < size; k++) begin
                gen_word(mode, w);
                exp_q.push_back({8'(c), w});
            end
        end
        m_evidx = (m_evidx + 1) % NCHAN;
        m_events++;
        pattern_init = 1'b1;
        tick();
        pattern_init = 1'b0;
    endtask

    task automatic pulse_done();
        ddr_done = 1'b1;
        tick();
        ddr_done = 1'b0;
        if (m_pend == 0) m_under = 1'b1;
        else m_pend--;
    endtask

    task automatic finish_event(input bit with_done);
        int i = 0;
        while (hit_rdaddr == m_addr && i < TIMEOUT) begin
            tick();
            i++;
        end
        if (i >= TIMEOUT) chk("event_timeout", 64'(i), 64'(TIMEOUT - 1));
        m_addr = m_addr + 1'b1;
        m_pend++;
        chk("rdaddr", 64'(hit_rdaddr), 64'(m_addr));
        chk("pend_cnt", 64'(pend_cnt), 64'(m_pend));
        chk("drained", 64'(exp_q.size()), 64'd0);
        chk("hit_re_cnt", 64'(re_cnt), 64'(m_events));
        chk("size_ovf", 64'(size_ovf), 64'(m_ovf));
        if (with_done) pulse_done();
    endtask

    task automatic spill(input bit halt);
        haltrun_en = halt;
        newspill_reset = 1'b1;
        tick();
        newspill_reset = 1'b0;
        haltrun_en = 1'b0;
        m_alt = 1'b0; m_evidx = 0; m_pend = 0; m_ovf = 1'b0; m_under = 1'b0;
        if (!halt) begin
            m_cnt = '1; m_walk = 32'd1; m_prbs = 31'd1; m_addr = '0;
        end
        chk("spill_addr", 64'(hit_rdaddr), 64'(m_addr));
        chk("spill_pend", 64'(pend_cnt), 64'd0);
        chk("spill_flags", 64'({hit_over, hit_under, size_ovf}), 64'd0);
    endtask

    // FIFO full driver
    initial forever begin
        @(posedge serdesclk);
        #2;
        if (rand_full) fifo_full = NCHAN'($urandom) & NCHAN'($urandom) & NCHAN'($urandom);
        else fifo_full = forced_full;
    end

    always @(posedge serdesclk) full_at_edge <= fifo_full;

    // Output monitor: every write must be the next expected word for that channel
    int          mon_c;
    logic [39:0] mon_e;
    always @(negedge serdesclk) begin
        if (hit_re) re_cnt++;
        if (pattern_we != '0) begin
            chk("we_onehot", 64'($countones(pattern_we)), 64'd1);
            chk("we_while_full", 64'(pattern_we & full_at_edge), 64'd0);
            mon_c = 0;
            for (int c = 0; c < NCHAN; c++) if (pattern_we[c]) mon_c = c;
            if (exp_q.size() == 0) begin
                chk("spurious_we", 64'(pattern_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fifo_word", {24'd0, 8'(mon_c), pattern_data[mon_c*DATA_W +: DATA_W]}, {24'd0, mon_e});
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_we", 64'(pattern_we), 64'd0);
        chk("rst_data", 64'(pattern_data[63:0] | pattern_data[127:64]), 64'd0);
        chk("rst_re_addr", 64'({hit_re, hit_rdaddr}), 64'd0);
        chk("rst_pend_flags", 64'({pend_cnt, hit_over, hit_under, size_ovf}), 64'd0);
        serdesclk_resetn = 1'b1;
        tick();

        // Rotating ownership, counter mode, 16 words per event
        for (int e = 0; e < NCHAN; e++) begin
            start_event(2, TAG_W'(20'hA0000 + e), 2'b00);
            finish_event(1);
        end

        // Mid-payload stall on channel 1
        start_event(1, 20'h00111, 2'b10);
        finish_event(1);
        start_event(8, 20'h00222, 2'b01);
        repeat (20) tick();
        forced_full = 4'b0010;
        repeat (10) tick();
        forced_full = '0;
        finish_event(1);

        // Shared event and oversize event
        start_event(SHARE_HITS, 20'h5_1234, 2'b00);
        finish_event(1);
        chk("ovf_before", 64'(size_ovf), 64'd0);
        start_event(600, 20'hF_0F0F, 2'b00);
        finish_event(1);

        // Pending limit: third event waits in REQ until one ddr_done
        start_event(2, 20'h00301, 2'b00);
        finish_event(0);
        start_event(3, 20'h00302, 2'b00);
        finish_event(0);
        start_event(1, 20'h00303, 2'b00);
        repeat (20) tick();
        chk("req_hold_q", 64'(exp_q.size()), 64'(WPH + NCHAN));
        chk("req_hold_pend", 64'(pend_cnt), 64'(MAX_PEND));
        chk("req_hold_re", 64'(re_cnt), 64'(m_events - 1));
        pulse_done();
        finish_event(0);
        pulse_done();
        pulse_done();
        chk("pend_zero", 64'(pend_cnt), 64'd0);
        chk("under_before", 64'(hit_under), 64'd0);
        pulse_done();
        chk("hit_under", 64'(hit_under), 64'(m_under));

        // Spill restart with and without haltrun
        spill(1'b1);
        start_event(2, 20'h00401, 2'b00);
        finish_event(1);
        spill(1'b0);
        start_event(2, 20'h00402, 2'b00);
        finish_event(1);

        // Random events under random backpressure
        rand_full = 1'b1;
        for (int e = 0; e < 24; e++) begin
            start_event($urandom_range(0, 6), TAG_W'($urandom), 2'($urandom_range(0, 3)));
            finish_event(1);
        end
        rand_full = 1'b0;
        repeat (4) tick();
        chk("hit_over", 64'(hit_over), 64'd0);
        chk("final_pend", 64'(pend_cnt), 64'(m_pend));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_roc_pattern_gen.md
Name: multi_roc_pattern_gen

Overview:
Parametrised successor of the single-FIFO cluster pattern controller. Generates simulated ROC event data (header plus payload) into NCHAN SIM_ROC_FIFOs, rotating event ownership or sharing large events across channels. Reads hits-per-event from HIT_NO_TPSRAM and respects per-channel FIFO backpressure. Tracks outstanding events against DDR_DONE with a parametrised depth.

Parameters:
NCHAN, 4, number of SIM_ROC_FIFO channels (1,2,4,8)
DATA_W, 32, FIFO word width
HIT_W, 10, width of hit count from TPSRAM
TAG_W, 20, event tag width (header bits [TAG_W-1:0])
ADDR_W, 6, TPSRAM address width
WPH, 8, payload words per hit
SHARE_HITS, 512, hit count that triggers sharing across all channels
MAX_PEND, 2, max events generated but not yet acknowledged by ddr_done (1..7)

Ports:
serdesclk  in  1  clock
serdesclk_resetn  in  1  async active-low reset
newspill_reset  in  1  synchronous spill restart, 1-cycle pulse
haltrun_en  in  1  preserve counter and TPSRAM address across newspill_reset
pattern_init  in  1  start one event (pulse)
ddr_done  in  1  one event drained to DDR (pulse)
hit_in  in  HIT_W  hits for current event from TPSRAM
ewtag_in  in  TAG_W  event tag
pattern_mode  in  2  00 counter, 01 5s/As, 10 walking-one, 11 see Optional Feature
fifo_full  in  NCHAN  per-channel SIM_ROC_FIFO full
pattern_we  out  NCHAN  per-channel write enable
pattern_data  out  NCHAN*DATA_W  flattened, channel c at [c*DATA_W +: DATA_W]
hit_re  out  1  TPSRAM read enable
hit_rdaddr  out  ADDR_W  TPSRAM address
pend_cnt  out  3  events outstanding
hit_over, hit_under, size_ovf  out  1 each  sticky diagnostics

Behaviour:
- Reset: all outputs 0. Counter = all-ones, so the first payload word is 0. Walking-one = 1. State IDLE.
- newspill_reset, same clock domain, highest priority after async reset:
  - Clears everything as reset does.
  - If haltrun_en=1, keeps the payload counter, walking-one register and hit_rdaddr.
- FSM: IDLE -> REQ -> WAIT -> WAIT1 -> HEADER -> PAYLOAD -> NEXTCH -> (HEADER for next channel | DONE) -> IDLE.
  - IDLE: wait for pattern_init. A pulse arriving outside IDLE is dropped.
  - REQ: if pend_cnt < MAX_PEND, pulse hit_re for 1 cycle. Otherwise stay in REQ.
  - WAIT, WAIT1: 2-cycle RAM latency. hit_in is sampled at the end of WAIT1 and held for the whole event.
- Ownership: owner channel = event_idx, which rotates 0..NCHAN-1 and advances in DONE. Every channel gets a header per event; non-owners get size 0.
- Sharing: if hit_in == SHARE_HITS, every channel gets a payload of hit_in*WPH/NCHAN words, using the same header size. event_idx still advances.
- Header word:
  - [31:20] size in words, computed at 13+ bits.
  - If the size exceeds 4095, the field saturates to 0xFFF and size_ovf is set; the payload is still written in full.
  - [TAG_W-1:0] ewtag_in; bits between are 0.
- Backpressure: a word (header or payload) is written only when fifo_full[ch]=0. While full, the FSM holds the word, the counter and word_cnt. pattern_we[ch]=0 during stall.
- pattern_we and pattern_data are registered: data is valid on the same cycle as we. Only one channel is written per cycle.
- Payload modes:
  - 00: counter +1 per word, shared across channels, wraps 0xFFFFFFFF -> 0.
  - 01: alternates 0x55555555 / 0xAAAAAAAA, starting with 5s after reset.
  - 10: rotate-left walking one.
- DONE: 1-cycle hit_filled pulse and hit_rdaddr += 1 (wraps at 2^ADDR_W); then IDLE.
- pend_cnt:
  - +1 on hit_filled, -1 on ddr_done when pend_cnt>0. Simultaneous events leave it unchanged.
  - hit_under is set on ddr_done when pend_cnt=0.
  - hit_over is set on hit_filled when pend_cnt=MAX_PEND.
- hit_in=0: headers only, size 0, no payload words.

Optional Feature:
Macro PATTERN_PRBS_EN.
- Defined: mode 11 emits PRBS-31 (x^31+x^28+1), seed 0x00000001 on reset, advanced per payload word. haltrun_en preserves the LFSR state like the counter.
- Not defined: mode 11 behaves as mode 00 and the LFSR logic is absent.

Test Plan:
- NCHAN=4, mode 00, hit_in=2 for 4 events, ddr_done after each -> channel k (k = event number 0-3) gets header 0x010_xxxxx with 16 payload words 0..15, 16..31, ...; other channels get size-0 headers.
- NCHAN=1, hit_in=512 -> header [31:20]=0xFFF, size_ovf=1, 4096 payload words written.
- NCHAN=4, hit_in=512 -> each channel header size 0x400, 1024 words each, counter continuous across channels.
- fifo_full[1] high for 10 cycles mid-payload -> no we[1] during stall, data resumes with no gap or duplicate.
- 3 pattern_init with no ddr_done, MAX_PEND=2 -> third event stalls in REQ with pend_cnt=2; one ddr_done releases it. ddr_done with pend_cnt=0 -> hit_under=1.
- haltrun_en=1 then newspill_reset -> next payload continues the counter and hit_rdaddr; with haltrun_en=0 both restart at 0.
